// File: rtl/turf_hdr_framer.sv
// turf_hdr_framer: frames raw event-header beats into prefix + fixed-length body packets,
// padding stalled headers after a timeout.
module turf_hdr_framer #(
  parameter int HDR_WORDS = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rstb_i,
  input  logic        runrst_i,
  input  logic [63:0] s_hdr_tdata,
  input  logic        s_hdr_tvalid,
  output logic        s_hdr_tready,
  output logic [63:0] m_hdr_tdata,
  output logic        m_hdr_tvalid,
  input  logic        m_hdr_tready,
  output logic        m_hdr_tlast,
  output logic [31:0] event_count_o,
  output logic [15:0] err_count_o,
  output logic        frame_err_o
);
  typedef enum logic [1:0] {IDLE, PREFIX, BODY, PAD} state_t;
  localparam logic [3:0]  LAST = 4'(HDR_WORDS - 1);
  localparam logic [16:0] TMO  = 17'(TIMEOUT);
  state_t state;
  logic [3:0]  beat_cnt, bc;
  logic [15:0] tmo_cnt, tc;
  logic free, body, last, pad_last, stall, tmo_hit, tlast_load;
  // The cycle the prefix is accepted already behaves as a BODY cycle with fresh counters.
  always_comb begin
    free         = !m_hdr_tvalid || m_hdr_tready;
    body         = state == BODY || (state == PREFIX && m_hdr_tvalid && m_hdr_tready);
    bc           = state == PREFIX ? 4'd0 : beat_cnt;
    tc           = state == PREFIX ? 16'd0 : tmo_cnt;
    last         = bc == LAST;
    pad_last     = beat_cnt == LAST;
    stall        = body && free && !s_hdr_tvalid;
    tmo_hit      = stall && ({1'b0, tc} + 17'd1 >= TMO);
    s_hdr_tready = body && free;
    tlast_load   = (s_hdr_tready && s_hdr_tvalid && last) || (state == PAD && free && pad_last);
  end
  always_ff @(posedge sysclk_i or negedge sysclk_rstb_i) begin
    if (!sysclk_rstb_i) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      tmo_cnt       <= '0;
      m_hdr_tdata   <= '0;
      m_hdr_tvalid  <= 1'b0;
      m_hdr_tlast   <= 1'b0;
      event_count_o <= '0;
      err_count_o   <= '0;
      frame_err_o   <= 1'b0;
    end else begin
      frame_err_o   <= 1'b0;
      event_count_o <= runrst_i ? 32'd0 : event_count_o + 32'(tlast_load);
      if (m_hdr_tvalid && m_hdr_tready) m_hdr_tvalid <= 1'b0;
      case (state)
        IDLE: if (s_hdr_tvalid && free) begin
          m_hdr_tdata  <= {8'hA5, LAST + 4'd1, 4'h0, 16'h0000, event_count_o};
          m_hdr_tvalid <= 1'b1;
          m_hdr_tlast  <= 1'b0;
          state        <= PREFIX;
        end
        PAD: if (free) begin
          m_hdr_tdata  <= 64'hDEAD_DEAD_DEAD_DEAD;
          m_hdr_tvalid <= 1'b1;
          m_hdr_tlast  <= pad_last;
          beat_cnt     <= beat_cnt + 4'd1;
          if (pad_last) state <= IDLE;
        end
        default: if (body) begin
          state    <= BODY;
          beat_cnt <= bc;
          tmo_cnt  <= tc;
          if (s_hdr_tready && s_hdr_tvalid) begin
            m_hdr_tdata  <= s_hdr_tdata;
            m_hdr_tvalid <= 1'b1;
            m_hdr_tlast  <= last;
            beat_cnt     <= bc + 4'd1;
            tmo_cnt      <= '0;
            if (last) state <= IDLE;
          end else if (tmo_hit) begin
            state       <= PAD;
            frame_err_o <= 1'b1;
            err_count_o <= err_count_o + 16'(err_count_o != 16'hFFFF);
          end else if (stall) begin
            tmo_cnt <= tc + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_turf_hdr_framer.sv
// tb_turf_hdr_framer: directed vector bench for the header framer (HDR_WORDS=2, TIMEOUT=8).
module tb_turf_hdr_framer;
  logic        clk = 1'b0, rstb = 1'b0, runrst = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast, frame_err;
  logic        m_tready = 1'b1, rand_ready = 1'b0;
  logic [31:0] event_count;
  logic [15:0] err_count;
  int checks = 0, fails = 0, err_pulses = 0;
  logic [64:0] beats[$];
  logic        stalled = 1'b0;
  logic [64:0] held = '0;

  turf_hdr_framer #(.HDR_WORDS(2), .TIMEOUT(8)) dut (
    .sysclk_i(clk), .sysclk_rstb_i(rstb), .runrst_i(runrst),
    .s_hdr_tdata(s_tdata), .s_hdr_tvalid(s_tvalid), .s_hdr_tready(s_tready),
    .m_hdr_tdata(m_tdata), .m_hdr_tvalid(m_tvalid), .m_hdr_tready(m_tready),
    .m_hdr_tlast(m_tlast), .event_count_o(event_count), .err_count_o(err_count),
    .frame_err_o(frame_err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(string n, logic [64:0] act, logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Capture accepted beats, count error pulses, and enforce hold-while-stalled.
  always @(negedge clk) begin
    if (rstb && m_tvalid && m_tready) beats.push_back({m_tlast, m_tdata});
    if (rstb && frame_err) err_pulses++;
    if (rstb && stalled) begin
      check("stall hold valid", 65'(m_tvalid), 65'd1);
      check("stall hold beat", {m_tlast, m_tdata}, held);
    end
    stalled = rstb && m_tvalid && !m_tready;
    held = {m_tlast, m_tdata};
  end

  function automatic logic [63:0] pfx(logic [31:0] e);
    return {8'hA5, 4'd2, 4'h0, 16'h0000, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(logic [63:0] d);
    logic hs = 1'b0;
    s_tdata = d;
    s_tvalid = 1'b1;
    for (int i = 0; i < 300 && !hs; i++) begin
      @(negedge clk);
      hs = s_tready;
      step();
    end
    s_tvalid = 1'b0;
    check("input handshake", 65'(hs), 65'd1);
  endtask

  task automatic drain(int n);
    for (int k = 0; k < 500 && beats.size() < n; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("beat count", 65'(beats.size()), 65'(n));
  endtask

  task automatic check_beat(string n, int i, logic [63:0] d, logic l);
    logic [64:0] b;
    b = i < beats.size() ? beats[i] : 'x;
    check(n, b, {l, d});
  endtask

  typedef struct {
    logic [63:0] d0, d1;
    logic [31:0] evt;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs = '{
      '{64'h1111, 64'h2222, 32'd0},
      '{64'h3333, 64'h4444, 32'd1},
      '{64'h5555, 64'h6666, 32'd2},
      '{64'h7777, 64'h8888, 32'd3},
      '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 32'd4},
      '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 32'd5},
      '{64'hA5A5_A5A5_0000_0001, 64'h5A5A_5A5A_0000_0002, 32'd6},
      '{64'h8000_0000_0000_0000, 64'h1, 32'd7},
      '{64'hCAFE_F00D_0000_0009, 64'hBEEF_0000_0000_0009, 32'd8}};
    #12;
    check("rst m_tvalid", 65'(m_tvalid), 65'd0);
    check("rst m_tlast", 65'(m_tlast), 65'd0);
    check("rst m_tdata", 65'(m_tdata), 65'd0);
    check("rst s_tready", 65'(s_tready), 65'd0);
    check("rst event_count", 65'(event_count), 65'd0);
    check("rst err_count", 65'(err_count), 65'd0);
    check("rst frame_err", 65'(frame_err), 65'd0);
    step();
    rstb = 1'b1;
    step();
    // Single normal packet, then three back-to-back, then five under random backpressure.
    send_beat(vecs[0].d0);
    send_beat(vecs[0].d1);
    drain(3);
    check("normal prefix literal", 65'(beats[0]), {1'b0, 64'hA520_0000_0000_0000});
    check("normal event_count", 65'(event_count), 65'd1);
    for (int i = 1; i < 4; i++) begin
      send_beat(vecs[i].d0);
      send_beat(vecs[i].d1);
    end
    drain(12);
    check("b2b event_count", 65'(event_count), 65'd4);
    rand_ready = 1'b1;
    for (int i = 4; i < 9; i++) begin
      send_beat(vecs[i].d0);
      send_beat(vecs[i].d1);
    end
    drain(27);
    rand_ready = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      check_beat($sformatf("pkt%0d prefix", i), 3 * i, pfx(vecs[i].evt), 1'b0);
      check_beat($sformatf("pkt%0d body0", i), 3 * i + 1, vecs[i].d0, 1'b0);
      check_beat($sformatf("pkt%0d body1", i), 3 * i + 2, vecs[i].d1, 1'b1);
    end
    check("bp event_count", 65'(event_count), 65'd9);
    check("bp no timeout", 65'(err_pulses), 65'd0);
    // Timeout: one body beat then silence; the eighth idle cycle triggers padding.
    beats.delete();
    send_beat(64'hAAAA);
    repeat (7) step();
    check("tmo not early", 65'(err_pulses), 65'd0);
    repeat (2) step();
    check("tmo pulse", 65'(err_pulses), 65'd1);
    drain(3);
    check_beat("tmo prefix", 0, pfx(32'd9), 1'b0);
    check_beat("tmo body", 1, 64'hAAAA, 1'b0);
    check_beat("tmo pad", 2, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1);
    check("tmo err_count", 65'(err_count), 65'd1);
    check("tmo event_count", 65'(event_count), 65'd10);
    check("tmo single pulse", 65'(err_pulses), 65'd1);
    // Run reset mid-packet and again coincident with the tlast load.
    beats.delete();
    send_beat(64'hB1);
    runrst = 1'b1;
    step();
    runrst = 1'b0;
    check("runrst mid clears", 65'(event_count), 65'd0);
    runrst = 1'b1;
    send_beat(64'hB2);
    runrst = 1'b0;
    check("runrst vs tlast", 65'(event_count), 65'd0);
    send_beat(64'hC1);
    send_beat(64'hC2);
    drain(6);
    check_beat("rr prefix", 0, pfx(32'd10), 1'b0);
    check_beat("rr body0", 1, 64'hB1, 1'b0);
    check_beat("rr body1", 2, 64'hB2, 1'b1);
    check_beat("rr next prefix", 3, pfx(32'd0), 1'b0);
    check_beat("rr next body0", 4, 64'hC1, 1'b0);
    check_beat("rr next body1", 5, 64'hC2, 1'b1);
    check("rr event_count", 65'(event_count), 65'd1);
    // Asynchronous reset in the middle of BODY.
    beats.delete();
    send_beat(64'hE1);
    #2;
    check("pre-arst valid", 65'(m_tvalid), 65'd1);
    rstb = 1'b0;
    #1;
    check("arst m_tvalid", 65'(m_tvalid), 65'd0);
    check("arst m_tdata", 65'(m_tdata), 65'd0);
    check("arst m_tlast", 65'(m_tlast), 65'd0);
    check("arst s_tready", 65'(s_tready), 65'd0);
    check("arst event_count", 65'(event_count), 65'd0);
    check("arst err_count", 65'(err_count), 65'd0);
    repeat (2) step();
    beats.delete();
    rstb = 1'b1;
    step();
    send_beat(64'hF1);
    send_beat(64'hF2);
    drain(3);
    check_beat("post-arst prefix", 0, pfx(32'd0), 1'b0);
    check_beat("post-arst body0", 1, 64'hF1, 1'b0);
    check_beat("post-arst body1", 2, 64'hF2, 1'b1);
    check("post-arst event_count", 65'(event_count), 65'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
